// File: rtl/i2c_master_ctrl.sv
`timescale 1ns/1ps
// i2c_master_ctrl: byte-level I2C master sequencer for START, WRITE, READ and STOP commands.
// Latency: 4*CLK_DIV+1 cycles from acceptance to rsp_valid for START/STOP, 36*CLK_DIV+1 for WRITE/READ.
// Backpressure: cmd_ready is high only in IDLE; a command is accepted on cmd_valid && cmd_ready.
//
// Ports:
//   clk, rst              - single rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready   - command handshake
//   cmd_op                - 00 START, 01 WRITE, 10 READ, 11 STOP
//   cmd_wdata             - WRITE byte, sent MSB first
//   cmd_ack_in            - ninth bit driven after a READ byte (0 = ACK, 1 = NACK)
//   rsp_valid             - one-cycle completion pulse
//   rsp_rdata             - byte received by the last READ
//   rsp_nack              - acknowledge bit sampled by the last WRITE (1 = NACK)
//   busy                  - a command is in progress
//   scl_drive, sda_drive  - open-drain controls: 0 pulls the line low, 1 releases it
//   scl_in, sda_in        - resolved bus levels
//
// Optional feature: define I2C_CLK_STRETCH_EN to honour slave clock stretching. The
// quarter counter then freezes during Q1/Q2 while SCL is released but still seen low.
// Without the macro scl_in is ignored and all timing is fixed.

module i2c_master_ctrl #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_wdata,
  input  logic       cmd_ack_in,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_nack,
  output logic       busy,
  output logic       scl_drive,
  output logic       sda_drive,
  input  logic       scl_in,
  input  logic       sda_in
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WRITE = 3'd2,
    ST_READ  = 3'd3,
    ST_STOP  = 3'd4
  } state_t;

  localparam logic [7:0] QMAX     = 8'(CLK_DIV - 1);
  localparam logic [3:0] LAST_BIT = 4'd8;

  state_t     state, state_n;
  logic [7:0] qcnt, qcnt_n;          // cycle within the current quarter
  logic [1:0] quarter, quarter_n;    // Q0..Q3 within the current bit step
  logic [3:0] bit_idx, bit_idx_n;    // bit step 0..8 for WRITE/READ

  logic [7:0] wdata_q;
  logic       ack_in_q;
  logic [7:0] rx_shift;
  logic       ack_smp;

  logic       scl_n, sda_n;
  logic       accept;
  logic       stall;
  logic       q_last;
  logic       sample;
  logic       done;

  logic [7:0] tx_byte;
  logic       ack_bit;
  logic [2:0] tx_sel;

  assign accept    = cmd_valid && (state == ST_IDLE);
  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);

`ifdef I2C_CLK_STRETCH_EN
  // A slave holding SCL low while we release it stretches the high phase.
  assign stall = (state != ST_IDLE) && ((quarter == 2'd1) || (quarter == 2'd2)) &&
                 scl_drive && !scl_in;
`else
  logic unused_scl_in;
  assign unused_scl_in = scl_in;
  assign stall         = 1'b0;
`endif

  // Last cycle of a quarter; sampling happens on the last cycle of Q2.
  assign q_last = (qcnt == QMAX) && !stall;
  assign sample = q_last && (quarter == 2'd2);

  // On the acceptance cycle the registered copies are not loaded yet, so the
  // first drive values come straight from the command inputs.
  assign tx_byte = accept ? cmd_wdata  : wdata_q;
  assign ack_bit = accept ? cmd_ack_in : ack_in_q;
  assign tx_sel  = 3'd7 - bit_idx_n[2:0];

  // Next-state, counters and next line drive levels.
  always_comb begin
    state_n   = state;
    qcnt_n    = qcnt;
    quarter_n = quarter;
    bit_idx_n = bit_idx;
    done      = 1'b0;

    if (state == ST_IDLE) begin
      if (accept) begin
        qcnt_n    = 8'd0;
        quarter_n = 2'd0;
        bit_idx_n = 4'd0;
        case (cmd_op)
          2'b00:   state_n = ST_START;
          2'b01:   state_n = ST_WRITE;
          2'b10:   state_n = ST_READ;
          default: state_n = ST_STOP;
        endcase
      end
    end else if (!stall) begin
      if (qcnt != QMAX) begin
        qcnt_n = qcnt + 8'd1;
      end else begin
        qcnt_n = 8'd0;
        if (quarter != 2'd3) begin
          quarter_n = quarter + 2'd1;
        end else begin
          quarter_n = 2'd0;
          if (((state == ST_WRITE) || (state == ST_READ)) && (bit_idx != LAST_BIT)) begin
            bit_idx_n = bit_idx + 4'd1;
          end else begin
            state_n = ST_IDLE;
            done    = 1'b1;
          end
        end
      end
    end

    // Line levels follow the phase we are entering; in IDLE they simply hold.
    scl_n = scl_drive;
    sda_n = sda_drive;
    case (state_n)
      ST_START: begin
        case (quarter_n)
          2'd0:    sda_n = 1'b1;
          2'd1:    scl_n = 1'b1;
          2'd2:    sda_n = 1'b0;
          default: scl_n = 1'b0;
        endcase
      end
      ST_WRITE, ST_READ: begin
        if (bit_idx_n == LAST_BIT) begin
          sda_n = (state_n == ST_WRITE) ? 1'b1 : ack_bit;
        end else begin
          sda_n = (state_n == ST_WRITE) ? tx_byte[tx_sel] : 1'b1;
        end
        scl_n = (quarter_n == 2'd1) || (quarter_n == 2'd2);
      end
      ST_STOP: begin
        case (quarter_n)
          2'd0: begin
            scl_n = 1'b0;
            sda_n = 1'b0;
          end
          2'd1: begin
            scl_n = 1'b1;
            sda_n = 1'b0;
          end
          default: begin
            scl_n = 1'b1;
            sda_n = 1'b1;
          end
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      qcnt      <= 8'd0;
      quarter   <= 2'd0;
      bit_idx   <= 4'd0;
      scl_drive <= 1'b1;
      sda_drive <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
      rsp_nack  <= 1'b0;
      wdata_q   <= 8'h00;
      ack_in_q  <= 1'b0;
      rx_shift  <= 8'h00;
      ack_smp   <= 1'b0;
    end else begin
      state     <= state_n;
      qcnt      <= qcnt_n;
      quarter   <= quarter_n;
      bit_idx   <= bit_idx_n;
      scl_drive <= scl_n;
      sda_drive <= sda_n;
      rsp_valid <= done;

      if (accept) begin
        wdata_q  <= cmd_wdata;
        ack_in_q <= cmd_ack_in;
      end

      if (sample) begin
        if ((state == ST_WRITE) && (bit_idx == LAST_BIT)) begin
          ack_smp <= sda_in;
        end
        if ((state == ST_READ) && (bit_idx != LAST_BIT)) begin
          rx_shift <= {rx_shift[6:0], sda_in};
        end
      end

      // Results are published together with the completion pulse.
      if (done) begin
        case (state)
          ST_READ: begin
            rsp_rdata <= rx_shift;
            rsp_nack  <= 1'b0;
          end
          ST_WRITE: rsp_nack <= ack_smp;
          default:  rsp_nack <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
`timescale 1ns/1ps
// tb_i2c_master_ctrl: self-checking bench with a simple I2C slave model and a
// response scoreboard (expected rdata/nack/latency queued at issue, compared at rsp_valid).
module tb_i2c_master_ctrl;

  localparam int D = 4;
`ifdef I2C_CLK_STRETCH_EN
  localparam int STR = 20;
`else
  localparam int STR = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_wdata;
  logic       cmd_ack_in;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_nack;
  logic       busy;
  logic       scl_drive, sda_drive;
  logic       scl_in, sda_in;

  logic slave_sda = 1'b1;
  logic slave_scl = 1'b1;
  assign sda_in = sda_drive & slave_sda;
  assign scl_in = scl_drive & slave_scl;

  always #5 clk = ~clk;

  i2c_master_ctrl #(.CLK_DIV(D)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_wdata(cmd_wdata), .cmd_ack_in(cmd_ack_in),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack),
    .busy(busy), .scl_drive(scl_drive), .sda_drive(sda_drive),
    .scl_in(scl_in), .sda_in(sda_in)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] rdata;
    logic       nack;
    int         lat;
    int         acc;
  } exp_t;
  exp_t sb[$];

  // Slave model controls (written only by the stimulus process).
  int         mode = 0;          // 0 idle, 1 write+ACK, 2 read, 3 absent (SDA pulled up)
  logic [7:0] sdata = 8'h00;
  logic       stretch_req = 1'b0;

  // Slave model state (written only by the monitor process).
  int         k = 0;             // SCL rising edges seen in the current command
  logic [7:0] cap = 8'h00;       // SDA level at each of the first 8 SCL rises
  logic       b9 = 1'b0;         // master's SDA drive at the 9th SCL rise
  logic       prev_scl = 1'b1;
  logic       prev_busy = 1'b0;
  int         sc = 0;

  always @(posedge clk) begin
    #2;
    if (sc > 0) begin
      sc = sc - 1;
      if (sc == 0) slave_scl = 1'b1;
    end
    if (busy && !prev_busy) k = 0;
    prev_busy = busy;
    if (scl_drive && !prev_scl) begin
      if (k < 8) cap = {cap[6:0], sda_in};
      if (k == 8) b9 = sda_drive;
      if (stretch_req && k == 2) begin
        slave_scl = 1'b0;
        sc = 20;
      end
      k = k + 1;
    end
    prev_scl = scl_drive;
    if (!scl_drive) begin
      case (mode)
        1:       slave_sda = (k == 8) ? 1'b0 : 1'b1;
        2:       slave_sda = (k < 8) ? sdata[7-k] : 1'b1;
        default: slave_sda = 1'b1;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called on a negedge with the DUT idle; returns on the negedge where rsp_valid is seen.
  task automatic do_cmd(input logic [1:0] op, input logic [7:0] wd, input logic ack,
                        input logic [7:0] erd, input logic enack, input int elat);
    exp_t e;
    bit   got;
    check("ready_before_issue", {31'd0, cmd_ready}, 32'd1);
    e.rdata = erd;
    e.nack  = enack;
    e.lat   = elat;
    e.acc   = cyc;
    sb.push_back(e);
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_wdata  = wd;
    cmd_ack_in = ack;
    @(negedge clk);
    cmd_valid  = 1'b0;
    cmd_wdata  = ~wd;
    cmd_ack_in = ~ack;
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    check("ready_low_after_accept", {31'd0, cmd_ready}, 32'd0);
    got = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      if (rsp_valid) got = 1'b1;
      else @(negedge clk);
    end
    e = sb.pop_front();
    if (!got) begin
      check("rsp_timeout", 32'd0, 32'd1);
    end else begin
      check("latency", cyc - e.acc, e.lat);
      check("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, e.rdata});
      check("rsp_nack", {31'd0, rsp_nack}, {31'd0, e.nack});
      check("ready_with_rsp", {31'd0, cmd_ready}, 32'd1);
    end
  endtask

  initial begin
    int   vcount;
    bit   hit;
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_op     = 2'b00;
    cmd_wdata  = 8'h00;
    cmd_ack_in = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_scl", {31'd0, scl_drive}, 32'd1);
    check("rst_sda", {31'd0, sda_drive}, 32'd1);
    check("rst_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rdata", {24'd0, rsp_rdata}, 32'd0);
    check("rst_nack", {31'd0, rsp_nack}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // START from released bus, then idle holds SCL/SDA low.
    mode = 0;
    do_cmd(2'b00, 8'h00, 1'b0, 8'h00, 1'b0, 4*D+1);
    check("start_idle_scl", {31'd0, scl_drive}, 32'd0);
    check("start_idle_sda", {31'd0, sda_drive}, 32'd0);

    // WRITE 0xA5 with ACK, then back-to-back WRITE 0x3C with no slave.
    mode = 1;
    do_cmd(2'b01, 8'hA5, 1'b0, 8'h00, 1'b0, 36*D+1);
    check("write_bits_a5", {24'd0, cap}, 32'h0000_00A5);
    mode = 3;
    do_cmd(2'b01, 8'h3C, 1'b0, 8'h00, 1'b1, 36*D+1);
    check("write_bits_3c", {24'd0, cap}, 32'h0000_003C);

    // READs with NACK and ACK in the ninth bit.
    mode = 2;
    sdata = 8'h96;
    do_cmd(2'b10, 8'h00, 1'b1, 8'h96, 1'b0, 36*D+1);
    check("read_bit9_nack", {31'd0, b9}, 32'd1);
    sdata = 8'h5A;
    do_cmd(2'b10, 8'h00, 1'b0, 8'h5A, 1'b0, 36*D+1);
    check("read_bit9_ack", {31'd0, b9}, 32'd0);

    // WRITE with the slave holding SCL low for 20 cycles in bit 3.
    mode = 1;
    stretch_req = 1'b1;
    do_cmd(2'b01, 8'hC3, 1'b0, 8'h5A, 1'b0, 36*D+1+STR);
    stretch_req = 1'b0;
    check("stretch_write_bits", {24'd0, cap}, 32'h0000_00C3);

    // STOP keeps rdata, releases both lines, single-cycle response.
    mode = 0;
    do_cmd(2'b11, 8'h00, 1'b0, 8'h5A, 1'b0, 4*D+1);
    check("stop_scl", {31'd0, scl_drive}, 32'd1);
    check("stop_sda", {31'd0, sda_drive}, 32'd1);
    @(negedge clk);
    check("rsp_pulse_one_cycle", {31'd0, rsp_valid}, 32'd0);

    // Reset during bit 4 of a READ.
    mode = 2;
    sdata = 8'hF0;
    cmd_valid = 1'b1;
    cmd_op = 2'b10;
    cmd_ack_in = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 1000 && !hit; i++) begin
      if (k >= 4) hit = 1'b1;
      else @(negedge clk);
    end
    check("reach_read_bit4", {31'd0, hit}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_scl", {31'd0, scl_drive}, 32'd1);
    check("abort_sda", {31'd0, sda_drive}, 32'd1);
    check("abort_ready", {31'd0, cmd_ready}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    vcount = (rsp_valid === 1'b1) ? 1 : 0;
    repeat (100) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) vcount++;
    end
    check("abort_no_rsp", vcount, 32'd0);
    mode = 0;
    do_cmd(2'b11, 8'h00, 1'b0, 8'h00, 1'b0, 4*D+1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_master_ctrl.md
I2C_MASTER_CTRL -- requirements
Module: i2c_master_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning clk cycles per SCL quarter-period; legal values are 2..255.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port cmd_valid, input, 1, command request.
REQ-005 SHALL have port cmd_ready, output, 1, controller accepting commands.
REQ-006 SHALL have port cmd_op, input, 2, operation: 00 START, 01 WRITE, 10 READ, 11 STOP.
REQ-007 SHALL have port cmd_wdata, input, 8, WRITE byte, sent MSB first.
REQ-008 SHALL have port cmd_ack_in, input, 1, READ ninth-bit value: 0 = ACK, 1 = NACK.
REQ-009 SHALL have port rsp_valid, output, 1, one-cycle completion pulse.
REQ-010 SHALL have port rsp_rdata, output, 8, READ result.
REQ-011 SHALL have port rsp_nack, output, 1, sampled WRITE ack bit (1 = NACK).
REQ-012 SHALL have port busy, output, 1, command in progress.
REQ-013 SHALL have ports scl_drive and sda_drive, output, 1 each, open-drain controls: 0 pulls the line low, 1 releases it.
REQ-014 SHALL have ports scl_in and sda_in, input, 1 each, resolved bus levels.

Function
REQ-015 SHALL use states IDLE, START, WRITE, READ, STOP; each bit step is four quarters Q0..Q3, each CLK_DIV cycles long, timed by a quarter counter.
REQ-016 SHALL accept a command on the cycle where cmd_valid && cmd_ready; cmd_ready is 1 only in IDLE and falls on the next cycle; cmd inputs are ignored otherwise.
REQ-017 SHALL register cmd_op, cmd_wdata and cmd_ack_in at acceptance; later input changes have no effect.
REQ-018 START SHALL run Q0 SDA released; Q1 SCL released; Q2 SDA low; Q3 SCL low. This gives a repeated START when SCL is initially low.
REQ-019 WRITE SHALL run 9 bit steps, each: Q0 SCL low and SDA set (drive 0 for a 0 bit, release for a 1 bit); Q1–Q2 SCL released; Q3 SCL low. Bit 9 releases SDA; sda_in is sampled on the last cycle of Q2 into rsp_nack.
REQ-020 READ SHALL run 9 bit steps with SDA released for bits 1–8, sampling sda_in MSB-first on the last cycle of Q2 into rsp_rdata; bit 9 drives cmd_ack_in.
REQ-021 STOP SHALL run Q0 SCL low, SDA low; Q1 SCL released; Q2 SDA released; Q3 hold both released.
REQ-022 SHALL assert rsp_valid for exactly one cycle, the cycle after the final quarter; cmd_ready rises in that same cycle.
REQ-023 Acceptance-to-rsp_valid latency SHALL be 4*CLK_DIV+1 cycles for START/STOP and 36*CLK_DIV+1 for WRITE/READ, excluding stretch stalls.
REQ-024 On START/STOP completion, rsp_nack SHALL be 0 and rsp_rdata SHALL keep its previous value; on WRITE completion rsp_rdata is unchanged.
REQ-025 busy SHALL equal (state != IDLE).
REQ-026 In IDLE, scl_drive and sda_drive SHALL hold their last value (released after STOP or reset; SCL low after START, WRITE or READ).
REQ-027 A command back-to-back with rsp_valid SHALL start on the cycle after its acceptance with no extra idle quarter.

Reset
REQ-028 When rst=1 at a clock edge, the block SHALL reset as follows: state IDLE; scl_drive=1; sda_drive=1; cmd_ready=1; rsp_valid=0; rsp_rdata=0x00; rsp_nack=0; busy=0; counters 0.
REQ-029 Reset mid-command SHALL abort the command with no STOP and no rsp_valid, releasing both lines on the next edge.

Configuration
REQ-030 Macro I2C_CLK_STRETCH_EN, when defined, SHALL freeze the quarter counter in any cycle of Q1/Q2 where scl_drive=1 and scl_in=0; timing resumes when scl_in=1.
REQ-031 Without I2C_CLK_STRETCH_EN, scl_in SHALL be unused and timing is fixed per REQ-023.

Verification
REQ-032 CLK_DIV=4, START then WRITE 0xA5 with the slave ACKing -> SDA during SCL high is 1,0,1,0,0,1,0,1; rsp_nack=0; rsp_valid at acceptance+145.
REQ-033 WRITE 0x3C with no slave (SDA pulled up) -> rsp_nack=1.
REQ-034 READ with cmd_ack_in=1 and the slave returning 0x96 -> rsp_rdata=0x96; master releases SDA on bit 9; latency 145 cycles.
REQ-035 Macro defined, slave holds SCL low for 20 cycles during bit 3 of a WRITE -> rsp_valid delayed by exactly 20 cycles; data unchanged.
REQ-036 rst asserted mid-READ bit 4 -> next cycle scl_drive=1, sda_drive=1, cmd_ready=1, no rsp_valid; STOP accepted afterwards completes in 17 cycles.
